// File: rtl/pwm_dac.sv
// pwm_dac: turns the mixer's unsigned sample stream into a 1-bit PWM audio output.
// Each PWM period is 2^WIDTH clocks. At each period start the duty register takes
// the newest sample. If no new sample arrived since the last period start, the
// duty register keeps its value and a sticky underrun flag is set.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   en           - run request; deasserting it stops at the end of the current period
//   mixed_sample - unsigned sample from the mixer
//   sample_valid - mixed_sample is valid this cycle (captured into pending)
//   underrun_clr - clears the sticky underrun flag
//   pwm_out      - PWM audio bit
//   sample_tick  - one-cycle pulse at each period start while running
//   underrun     - sticky: a period started without a fresh sample
//   busy         - high whenever the block is not idle
module pwm_dac #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] mixed_sample,
  input  logic             sample_valid,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             sample_tick,
  output logic             underrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             fresh_q, fresh_d;
  logic             underrun_d;
  logic             underrun_set;
  logic             wrap;
  logic             pwm_d, tick_d, busy_d;

  // Last cycle of the period: the counter is at its maximum value.
  assign wrap = (counter_q == {WIDTH{1'b1}});

  // Next-state, datapath and output decode.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    duty_d       = duty_q;
    pending_d    = pending_q;
    fresh_d      = fresh_q;
    underrun_set = 1'b0;

    // Capture runs in every state; only the duty load is limited to RUN wraps.
    if (sample_valid) begin
      pending_d = mixed_sample;
      fresh_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        counter_d = '0;
        duty_d    = '0;
        if (en) begin
          state_d = RUN;
        end
      end

      RUN: begin
        counter_d = counter_q + WIDTH'(1);
        if (wrap) begin
          // A sample arriving on the wrap cycle itself bypasses pending.
          if (sample_valid) begin
            duty_d  = mixed_sample;
            fresh_d = 1'b0;
          end else if (fresh_q) begin
            duty_d  = pending_q;
            fresh_d = 1'b0;
          end else begin
            underrun_set = 1'b1;
          end
        end
        if (!en) begin
          state_d = STOPPING;
        end
      end

      STOPPING: begin
        counter_d = counter_q + WIDTH'(1);
        if (wrap) begin
          // Finishing the period wins over a late re-enable.
          state_d   = IDLE;
          counter_d = '0;
          duty_d    = '0;
          fresh_d   = 1'b0;
        end else if (en) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d   = IDLE;
        counter_d = '0;
        duty_d    = '0;
      end
    endcase

    // Set wins over a coincident clear.
    underrun_d = underrun_set | (underrun & ~underrun_clr);

    // Outputs are computed from next-state values so the registered copies
    // line up with the state they describe.
    busy_d = (state_d != IDLE);
    pwm_d  = busy_d && (counter_d < duty_d);
    tick_d = (state_d == RUN) && (counter_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      duty_q      <= '0;
      pending_q   <= '0;
      fresh_q     <= 1'b0;
      underrun    <= 1'b0;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      duty_q      <= duty_d;
      pending_q   <= pending_d;
      fresh_q     <= fresh_d;
      underrun    <= underrun_d;
      pwm_out     <= pwm_d;
      sample_tick <= tick_d;
      busy        <= busy_d;
    end
  end

endmodule
